execute_stage: RTL and testbench

//  Execute stage: consumes the registered operands/control produced by the register-fetch pipeline register.

---
 rtl/arm_ex_pkg.sv | 77 +++++++
 rtl/ex_alu.sv | 57 +++++
 rtl/execute_stage.sv | 137 +++++++++++++
 tb/tb_execute_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ex_pkg.sv
// Shared constants for the execute stage: widths, ARM DP opcodes, condition codes,
// CPSR flag bit positions and the condition-code evaluation helper.
package arm_ex_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned FLAG_W     = 4;

  // CPSR flag bit indices within {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ARM data-processing opcodes
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // ARM condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;

  // Evaluate an ARM condition field against {N,Z,C,V}; NV (1111) never passes
  function automatic logic cond_check(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      CC_EQ:   cond_check = z;
      CC_NE:   cond_check = !z;
      CC_CS:   cond_check = c;
      CC_CC:   cond_check = !c;
      CC_MI:   cond_check = n;
      CC_PL:   cond_check = !n;
      CC_VS:   cond_check = v;
      CC_VC:   cond_check = !v;
      CC_HI:   cond_check = c && !z;
      CC_LS:   cond_check = !c || z;
      CC_GE:   cond_check = (n == v);
      CC_LT:   cond_check = (n != v);
      CC_GT:   cond_check = !z && (n == v);
      CC_LE:   cond_check = z || (n != v);
      CC_AL:   cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ARM data-processing ALU.
// Ports: a, b operands; op DP opcode; cin current CPSR.C (ADC/SBC/RSC);
//        result; n/z/c/v computed flags; arith=1 when c/v are meaningful;
//        writes_rd=0 for the test ops TST/TEQ/CMP/CMN.
module ex_alu
  import arm_ex_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v,
  output logic              arith,
  output logic              writes_rd
);

  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              ci;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] logic_res;

  // All arithmetic is x + y + ci; subtraction uses the inverted operand so C = no borrow
  always_comb begin
    x         = a;
    y         = b;
    ci        = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op)
      OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
      OP_ADD, OP_CMN: ci = 1'b0;
      OP_ADC:         ci = cin;
      OP_SBC:         begin y = ~b; ci = cin; end
      OP_RSC:         begin x = b; y = ~a; ci = cin; end
      OP_AND, OP_TST: begin arith = 1'b0; logic_res = a & b; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = a ^ b; end
      OP_ORR:         begin arith = 1'b0; logic_res = a | b; end
      OP_MOV:         begin arith = 1'b0; logic_res = b; end
      OP_BIC:         begin arith = 1'b0; logic_res = a & ~b; end
      default:        begin arith = 1'b0; logic_res = ~b; end
    endcase
    sum       = (DATA_W+1)'(x) + (DATA_W+1)'(y) + (DATA_W+1)'(ci);
    result    = arith ? sum[DATA_W-1:0] : logic_res;
    n         = result[DATA_W-1];
    z         = (result == '0);
    c         = sum[DATA_W];
    v         = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
    writes_rd = (op[3:2] != 2'b10);
  end

endmodule

// File: rtl/execute_stage.sv
// ARM execute stage: condition check against the CPSR, ALU / address / branch
// resolution, CPSR NZCV ownership and the EX/MEM output register (1-cycle latency).
// Ports: clk, reset (sync, active-high); valid_in/stall_in/flush_in/ready_out handshake;
//        operand and control inputs from register fetch; registered EX/MEM outputs;
//        flags_out is the current CPSR {N,Z,C,V}.
module execute_stage
  import arm_ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic [DATA_W-1:0]     data1_in,
  input  logic [DATA_W-1:0]     data2_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [4:0]            opcode_in,
  input  logic [3:0]            cond_in,
  input  logic                  cpsr_write_in,
  input  logic                  is_branch_in,
  input  logic                  link_in,
  input  logic                  load_store_in,
  input  logic                  pre_post_in,
  input  logic                  up_down_in,
  input  logic                  byte_word_in,
  input  logic                  write_back_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [REG_ADDR_W-1:0] rn_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     result_out,
  output logic [DATA_W-1:0]     addr_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [DATA_W-1:0]     wb_value_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [REG_ADDR_W-1:0] rn_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  byte_out,
  output logic                  wb_en_out,
  output logic                  branch_taken_out,
  output logic [DATA_W-1:0]     branch_target_out,
  output logic [FLAG_W-1:0]     flags_out
);

  logic [FLAG_W-1:0] cpsr;
  logic [FLAG_W-1:0] cpsr_next;
  logic [DATA_W-1:0] alu_result;
  logic              alu_n, alu_z, alu_c, alu_v, alu_arith, alu_writes_rd;
  logic [DATA_W-1:0] offset_sum;
  logic              squash, accept, is_mem, is_dp;

  ex_alu u_alu (
    .a         (data1_in),
    .b         (data2_in),
    .op        (opcode_in[3:0]),
    .cin       (cpsr[FLAG_C]),
    .result    (alu_result),
    .n         (alu_n),
    .z         (alu_z),
    .c         (alu_c),
    .v         (alu_v),
    .arith     (alu_arith),
    .writes_rd (alu_writes_rd)
  );

  assign ready_out = !stall_in;
  assign flags_out = cpsr;

  // A taken branch sitting in EX/MEM means the instruction now at the input is wrong-path
  assign squash = branch_taken_out & valid_out;
  assign accept = valid_in & !squash & cond_check(cond_in, cpsr);
  assign is_mem = opcode_in[4] & !is_branch_in;
  assign is_dp  = !opcode_in[4] & !is_branch_in;

  assign offset_sum = up_down_in ? (data1_in + data2_in) : (data1_in - data2_in);

  // Flag update: logical ops leave C and V alone
  always_comb begin
    cpsr_next = cpsr;
    if (is_dp && cpsr_write_in) begin
      cpsr_next[FLAG_N] = alu_n;
      cpsr_next[FLAG_Z] = alu_z;
      if (alu_arith) begin
        cpsr_next[FLAG_C] = alu_c;
        cpsr_next[FLAG_V] = alu_v;
      end
    end
  end

  // EX/MEM register and CPSR; flush beats stall, stall beats squash/bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr              <= '0;
      valid_out         <= 1'b0;
      result_out        <= '0;
      addr_out          <= '0;
      store_data_out    <= '0;
      wb_value_out      <= '0;
      rd_out            <= '0;
      rn_out            <= '0;
      reg_write_out     <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      byte_out          <= 1'b0;
      wb_en_out         <= 1'b0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else if (flush_in || (!stall_in && !accept)) begin
      valid_out        <= 1'b0;
      reg_write_out    <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      byte_out         <= 1'b0;
      wb_en_out        <= 1'b0;
      branch_taken_out <= 1'b0;
    end else if (!stall_in) begin
      cpsr              <= cpsr_next;
      valid_out         <= 1'b1;
      result_out        <= is_branch_in ? (data1_in - DATA_W'(4)) : alu_result;
      addr_out          <= pre_post_in ? offset_sum : data1_in;
      store_data_out    <= store_data_in;
      wb_value_out      <= offset_sum;
      rd_out            <= (is_branch_in && link_in) ? REG_ADDR_W'(14) : rd_in;
      rn_out            <= rn_in;
      reg_write_out     <= is_branch_in ? link_in : (is_dp & alu_writes_rd);
      mem_read_out      <= is_mem & load_store_in;
      mem_write_out     <= is_mem & !load_store_in;
      byte_out          <= is_mem & byte_word_in;
      wb_en_out         <= is_mem & (write_back_in | !pre_post_in);
      branch_taken_out  <= is_branch_in;
      branch_target_out <= data1_in + data2_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table of {stimulus, expected} records plus
// hand-written stall / branch-link / flush / reset sequences, checked through a scoreboard queue.
module tb_execute_stage;

  typedef struct {
    logic        valid;
    logic [31:0] d1, d2, sd;
    logic [4:0]  opc;
    logic [3:0]  cond;
    logic        s, br, link, ls, pre, up, bw, wb;
    logic [3:0]  rd, rn;
  } in_t;

  // kind: 0 bubble, 1 data-processing, 2 memory, 3 branch, 4 every output
  typedef struct {
    int          kind;
    logic        valid, rw, mr, mw, wbe, bt, by;
    logic [31:0] result, addr, wbv, sd, target;
    logic [3:0]  rd, rn, flags;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam logic [3:0] AL = 4'hE;

  logic        clk, reset, valid_in, ready_out, stall_in, flush_in;
  logic [31:0] data1_in, data2_in, store_data_in;
  logic [4:0]  opcode_in;
  logic [3:0]  cond_in;
  logic        cpsr_write_in, is_branch_in, link_in, load_store_in, pre_post_in;
  logic        up_down_in, byte_word_in, write_back_in;
  logic [3:0]  rd_in, rn_in;
  logic        valid_out;
  logic [31:0] result_out, addr_out, store_data_out, wb_value_out, branch_target_out;
  logic [3:0]  rd_out, rn_out, flags_out;
  logic        reg_write_out, mem_read_out, mem_write_out, byte_out, wb_en_out, branch_taken_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .stall_in(stall_in), .flush_in(flush_in), .data1_in(data1_in), .data2_in(data2_in),
    .store_data_in(store_data_in), .opcode_in(opcode_in), .cond_in(cond_in),
    .cpsr_write_in(cpsr_write_in), .is_branch_in(is_branch_in), .link_in(link_in),
    .load_store_in(load_store_in), .pre_post_in(pre_post_in), .up_down_in(up_down_in),
    .byte_word_in(byte_word_in), .write_back_in(write_back_in), .rd_in(rd_in), .rn_in(rn_in),
    .valid_out(valid_out), .result_out(result_out), .addr_out(addr_out),
    .store_data_out(store_data_out), .wb_value_out(wb_value_out), .rd_out(rd_out),
    .rn_out(rn_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .byte_out(byte_out), .wb_en_out(wb_en_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
    .flags_out(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t dp_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] cnd, input logic s);
    in_t r;
    r = '{default: '0};
    r.valid = 1'b1; r.opc = {1'b0, op}; r.d1 = a; r.d2 = b; r.cond = cnd; r.s = s;
    r.rd = 4'd1; r.rn = 4'd2;
    return r;
  endfunction

  function automatic in_t mem_in(input logic ls, input logic pre, input logic up, input logic bw,
                                 input logic wb, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sdv);
    in_t r;
    r = '{default: '0};
    r.valid = 1'b1; r.opc = 5'h14; r.cond = AL; r.ls = ls; r.pre = pre; r.up = up;
    r.bw = bw; r.wb = wb; r.d1 = a; r.d2 = b; r.sd = sdv; r.rd = 4'd3; r.rn = 4'd5;
    return r;
  endfunction

  function automatic in_t br_in(input logic [3:0] cnd, input logic lnk, input logic [31:0] a,
                                input logic [31:0] b);
    in_t r;
    r = '{default: '0};
    r.valid = 1'b1; r.br = 1'b1; r.link = lnk; r.cond = cnd; r.d1 = a; r.d2 = b; r.rd = 4'd7;
    return r;
  endfunction

  function automatic exp_t ex_bub(input logic [3:0] f);
    exp_t r;
    r = '{default: '0};
    r.kind = 0; r.flags = f;
    return r;
  endfunction

  function automatic exp_t ex_dp(input logic [31:0] res, input logic rw, input logic [3:0] f);
    exp_t r;
    r = '{default: '0};
    r.kind = 1; r.valid = 1'b1; r.result = res; r.rw = rw; r.rd = 4'd1; r.flags = f;
    return r;
  endfunction

  function automatic exp_t ex_mem(input logic [31:0] ad, input logic [31:0] wv, input logic [31:0] sdv,
                                  input logic mr, input logic mw, input logic wbe, input logic by,
                                  input logic [3:0] f);
    exp_t r;
    r = '{default: '0};
    r.kind = 2; r.valid = 1'b1; r.addr = ad; r.wbv = wv; r.sd = sdv; r.mr = mr; r.mw = mw;
    r.wbe = wbe; r.by = by; r.rn = 4'd5; r.flags = f;
    return r;
  endfunction

  function automatic exp_t ex_br(input logic [31:0] tgt, input logic [31:0] res, input logic [3:0] rdv,
                                 input logic rw, input logic [3:0] f);
    exp_t r;
    r = '{default: '0};
    r.kind = 3; r.valid = 1'b1; r.bt = 1'b1; r.target = tgt; r.result = res; r.rd = rdv;
    r.rw = rw; r.flags = f;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, " valid"},     {31'b0, valid_out},        {31'b0, e.valid});
    cmp({tag, " reg_write"}, {31'b0, reg_write_out},    {31'b0, e.rw});
    cmp({tag, " mem_read"},  {31'b0, mem_read_out},     {31'b0, e.mr});
    cmp({tag, " mem_write"}, {31'b0, mem_write_out},    {31'b0, e.mw});
    cmp({tag, " wb_en"},     {31'b0, wb_en_out},        {31'b0, e.wbe});
    cmp({tag, " br_taken"},  {31'b0, branch_taken_out}, {31'b0, e.bt});
    cmp({tag, " flags"},     {28'b0, flags_out},        {28'b0, e.flags});
    if (e.kind == 1 || e.kind == 3 || e.kind == 4) begin
      cmp({tag, " result"}, result_out, e.result);
      cmp({tag, " rd"}, {28'b0, rd_out}, {28'b0, e.rd});
    end
    if (e.kind == 2 || e.kind == 4) begin
      cmp({tag, " addr"}, addr_out, e.addr);
      cmp({tag, " wb_value"}, wb_value_out, e.wbv);
      cmp({tag, " store_data"}, store_data_out, e.sd);
      cmp({tag, " rn"}, {28'b0, rn_out}, {28'b0, e.rn});
      cmp({tag, " byte"}, {31'b0, byte_out}, {31'b0, e.by});
    end
    if (e.kind == 3 || e.kind == 4)
      cmp({tag, " target"}, branch_target_out, e.target);
  endtask

  // Drive one cycle of stimulus, queue its expectation, clock, then check 1 time unit after the edge
  task automatic run(input string tag, input in_t v, input exp_t e,
                     input logic st, input logic fl, input logic rs);
    reset = rs; stall_in = st; flush_in = fl;
    valid_in = v.valid; data1_in = v.d1; data2_in = v.d2; store_data_in = v.sd;
    opcode_in = v.opc; cond_in = v.cond; cpsr_write_in = v.s; is_branch_in = v.br;
    link_in = v.link; load_store_in = v.ls; pre_post_in = v.pre; up_down_in = v.up;
    byte_word_in = v.bw; write_back_in = v.wb; rd_in = v.rd; rn_in = v.rn;
    sb.push_back(e);
    #1;
    cmp({tag, " ready"}, {31'b0, ready_out}, {31'b0, !st});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  vec_t tbl[17];
  exp_t zero_e;
  exp_t held;
  in_t  nop;

  initial begin
    zero_e = '{default: '0};
    zero_e.kind = 4;
    nop = '{default: '0};

    tbl[0]  = '{dp_in(4'h4, 32'h7FFF_FFFF, 32'h1, AL, 1'b1),  ex_dp(32'h8000_0000, 1'b1, 4'b1001)};
    tbl[1]  = '{dp_in(4'hA, 32'h5, 32'h5, AL, 1'b1),          ex_dp(32'h0, 1'b0, 4'b0110)};
    tbl[2]  = '{br_in(4'h0, 1'b0, 32'hF8, 32'h8),             ex_br(32'h100, 32'hF4, 4'd7, 1'b0, 4'b0110)};
    tbl[3]  = '{dp_in(4'h4, 32'h1, 32'h1, AL, 1'b0),          ex_bub(4'b0110)};
    tbl[4]  = '{dp_in(4'h2, 32'h9, 32'h1, 4'h1, 1'b1),        ex_bub(4'b0110)};
    tbl[5]  = '{dp_in(4'h5, 32'h1, 32'h2, AL, 1'b1),          ex_dp(32'h4, 1'b1, 4'b0000)};
    tbl[6]  = '{dp_in(4'h6, 32'h5, 32'h3, AL, 1'b0),          ex_dp(32'h1, 1'b1, 4'b0000)};
    tbl[7]  = '{dp_in(4'h3, 32'h1, 32'h0, AL, 1'b1),          ex_dp(32'hFFFF_FFFF, 1'b1, 4'b1000)};
    tbl[8]  = '{dp_in(4'h4, 32'h2, 32'h2, 4'h4, 1'b0),        ex_dp(32'h4, 1'b1, 4'b1000)};
    tbl[9]  = '{dp_in(4'hA, 32'h5, 32'h3, AL, 1'b1),          ex_dp(32'h2, 1'b0, 4'b0010)};
    tbl[10] = '{dp_in(4'h0, 32'hF0, 32'h0F, AL, 1'b1),        ex_dp(32'h0, 1'b1, 4'b0110)};
    tbl[11] = '{dp_in(4'hF, 32'h0, 32'h0, AL, 1'b0),          ex_dp(32'hFFFF_FFFF, 1'b1, 4'b0110)};
    tbl[12] = '{dp_in(4'hE, 32'hFF, 32'h0F, AL, 1'b0),        ex_dp(32'hF0, 1'b1, 4'b0110)};
    tbl[13] = '{dp_in(4'h4, 32'h1, 32'h1, 4'hF, 1'b0),        ex_bub(4'b0110)};
    tbl[14] = '{dp_in(4'h9, 32'h55, 32'h55, AL, 1'b1),        ex_dp(32'h0, 1'b0, 4'b0110)};
    tbl[15] = '{mem_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h4, 32'hDEAD),
                ex_mem(32'h1004, 32'h1004, 32'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110)};
    tbl[16] = '{mem_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h10, 32'hCAFE_BABE),
                ex_mem(32'h2000, 32'h1FF0, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110)};

    run("reset", nop, zero_e, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 17; k++)
      run($sformatf("vec%0d", k), tbl[k].i, tbl[k].e, 1'b0, 1'b0, 1'b0);

    // stall: outputs and flags frozen for three cycles while a new instruction waits
    held = ex_dp(32'h5, 1'b1, 4'b0110);
    run("pre_stall", dp_in(4'h4, 32'h2, 32'h3, AL, 1'b0), held, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      run($sformatf("stall%0d", k), dp_in(4'h4, 32'h1, 32'h1, AL, 1'b1), held, 1'b1, 1'b0, 1'b0);
    run("post_stall", dp_in(4'h4, 32'h1, 32'h1, AL, 1'b1), ex_dp(32'h2, 1'b1, 4'b0000), 1'b0, 1'b0, 1'b0);

    // branch-and-link, then the following input is squashed
    run("bl", br_in(AL, 1'b1, 32'h208, 32'h40), ex_br(32'h248, 32'h204, 4'd14, 1'b1, 4'b0000),
        1'b0, 1'b0, 1'b0);
    run("bl_squash", dp_in(4'h4, 32'h1, 32'h1, AL, 1'b0), ex_bub(4'b0000), 1'b0, 1'b0, 1'b0);

    // flush together with stall, then flush alone
    run("pre_flush", dp_in(4'h4, 32'h2, 32'h3, AL, 1'b0), ex_dp(32'h5, 1'b1, 4'b0000), 1'b0, 1'b0, 1'b0);
    run("flush_stall", dp_in(4'h4, 32'h1, 32'h1, AL, 1'b1), ex_bub(4'b0000), 1'b1, 1'b1, 1'b0);
    run("flush", dp_in(4'h4, 32'h1, 32'h1, AL, 1'b1), ex_bub(4'b0000), 1'b0, 1'b1, 1'b0);

    // reset mid-stream after flags were set
    run("adds_carry", dp_in(4'h4, 32'hFFFF_FFFF, 32'h1, AL, 1'b1), ex_dp(32'h0, 1'b1, 4'b0110),
        1'b0, 1'b0, 1'b0);
    run("mid_reset", dp_in(4'h4, 32'h3, 32'h4, AL, 1'b1), zero_e, 1'b0, 1'b0, 1'b1);
    run("after_reset", dp_in(4'h4, 32'h3, 32'h4, AL, 1'b0), ex_dp(32'h7, 1'b1, 4'b0000),
        1'b0, 1'b0, 1'b0);

    if (sb.size() != 0)
      cmp("scoreboard_leftover", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
